mem_arbiter: RTL

//  Shares the single-port word RAM (8-bit word address, 4-bit byte mask, sync write, comb read)

---
 rtl/mem_arb_pkg.sv | 22 ++
 rtl/mem_arbiter_lane_align.sv | 43 ++++
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D RAM arbiter: FSM states, RV32I load/store
// funct3 size codes and requester identifiers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/mem_arbiter_lane_align.sv
// Combinational byte-lane steering: funct3 size plus byte offset give the RAM byte mask,
// lane-replicated store data and the sign/zero-extended load value.
module lsu_lane_align
  import mem_arb_pkg::*;
(
  input  logic [2:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  mask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] byte_shifted;
  logic [31:0] half_shifted;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        zero_ext;

  // NOTE: every output gets a default first so no path through this block infers a latch.
  always_comb begin
    byte_shifted = rdata_i >> {offset_i, 3'b000};
    half_shifted = rdata_i >> {offset_i[1], 4'b0000};
    ld_byte      = byte_shifted[7:0];
    ld_half      = half_shifted[15:0];
    zero_ext     = size_i[2];
    mask_o       = 4'b1111;
    wdata_o      = wdata_i;
    rdata_o      = rdata_i;
    // Size 011/110/111 falls through to the word behaviour.
    if (size_i[1:0] == F3_B[1:0]) begin
      mask_o  = 4'b0001 << offset_i;
      wdata_o = {4{wdata_i[7:0]}};
      rdata_o = {{24{ld_byte[7] & ~zero_ext}}, ld_byte};
    end else if (size_i[1:0] == F3_H[1:0]) begin
      mask_o  = 4'b0011 << {offset_i[1], 1'b0};
      wdata_o = {2{wdata_i[15:0]}};
      rdata_o = {{16{ld_half[15] & ~zero_ext}}, ld_half};
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one word RAM between instruction fetch and the LSU, with starvation guard.
// Optional macro MEM_ARBITER_ALIGN_CHECK_EN enables misaligned/illegal-size rejection.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [31:0]       i_req_addr,
  output logic              i_rsp_valid,
  output logic [31:0]       i_rsp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [31:0]       d_req_addr,
  input  logic [2:0]        d_req_size,
  input  logic [31:0]       d_req_wdata,
  output logic              d_rsp_valid,
  output logic [31:0]       d_rsp_data,
  output logic              d_rsp_err,
  output logic              ram_w_en,
  output logic [ADDR_W-1:0] ram_address,
  output logic [3:0]        ram_masking,
  output logic [31:0]       ram_write_data,
  input  logic [31:0]       ram_read_data
);

  localparam int SC_W = $clog2(STARVE_MAX + 1);
  localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

  state_e            state_q;
  port_e             port_q;
  logic [ADDR_W+1:0] addr_q;
  logic [2:0]        size_q;
  logic              we_q;
  logic [31:0]       wdata_q;
  logic [SC_W-1:0]   starve_q, starve_d;
  logic              i_rsp_valid_q, d_rsp_valid_q, d_rsp_err_q;
  logic [31:0]       i_rsp_data_q, d_rsp_data_q;

  logic        can_accept, i_win, accept, in_access, err;
  logic [1:0]  offset;
  logic [3:0]  mask;
  logic [31:0] wdata_rep, rdata_ext;

  // I-fetch ignores the byte offset; only the LSU steers lanes.
  assign offset = (port_q == PORT_D) ? addr_q[1:0] : 2'b00;

  lsu_lane_align u_align (
    .size_i   (size_q),
    .offset_i (offset),
    .wdata_i  (wdata_q),
    .rdata_i  (ram_read_data),
    .mask_o   (mask),
    .wdata_o  (wdata_rep),
    .rdata_o  (rdata_ext)
  );

  always_comb begin
`ifdef MEM_ARBITER_ALIGN_CHECK_EN
    err = (port_q == PORT_D) &&
          ((size_q == 3'b011) || (size_q[2:1] == 2'b11) || (we_q && size_q[2]) ||
           ((size_q[1:0] == F3_H[1:0]) && offset[0]) ||
           ((size_q == F3_W) && (offset != 2'b00)));
`else
    err = 1'b0;
`endif
  end

  always_comb begin
    can_accept  = (state_q != ACCESS) && !rst;
    i_win       = i_req_valid && (!d_req_valid || (starve_q == STARVE_LIM));
    i_req_ready = can_accept && (!d_req_valid || (starve_q == STARVE_LIM));
    d_req_ready = can_accept && !(i_req_valid && (starve_q == STARVE_LIM));
    accept      = can_accept && (i_req_valid || d_req_valid);
    starve_d    = starve_q;
    if (accept && i_req_valid) begin
      if (i_win)                         starve_d = '0;
      else if (starve_q != STARVE_LIM)   starve_d = starve_q + 1'b1;
    end
  end

  // RAM is driven only from latched request registers; a reset arriving during ACCESS
  // must suppress the write the RAM would otherwise take on the same edge.
  always_comb begin
    in_access      = (state_q == ACCESS);
    ram_address    = in_access ? addr_q[ADDR_W+1:2] : '0;
    ram_masking    = in_access ? mask : 4'b0000;
    ram_write_data = in_access ? wdata_rep : 32'd0;
    ram_w_en       = in_access && we_q && !err && !rst;
  end

  // NOTE: state is updated with non-blocking assignments only, so all registers see
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      port_q        <= PORT_I;
      addr_q        <= '0;
      size_q        <= F3_W;
      we_q          <= 1'b0;
      wdata_q       <= 32'd0;
      starve_q      <= '0;
      i_rsp_valid_q <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      i_rsp_data_q  <= 32'd0;
      d_rsp_data_q  <= 32'd0;
      d_rsp_err_q   <= 1'b0;
    end else begin
      i_rsp_valid_q <= 1'b0;
      d_rsp_valid_q <= 1'b0;
      starve_q      <= starve_d;
      case (state_q)
        ACCESS: begin
          state_q <= RESP;
          if (port_q == PORT_I) begin
            i_rsp_valid_q <= 1'b1;
            i_rsp_data_q  <= rdata_ext;
          end else begin
            d_rsp_valid_q <= 1'b1;
            d_rsp_data_q  <= (we_q || err) ? 32'd0 : rdata_ext;
            d_rsp_err_q   <= err;
          end
        end
        default: state_q <= accept ? ACCESS : IDLE;
      endcase
      if (accept) begin
        if (i_win) begin
          port_q  <= PORT_I;
          addr_q  <= i_req_addr[ADDR_W+1:0];
          size_q  <= F3_W;
          we_q    <= 1'b0;
          wdata_q <= 32'd0;
        end else begin
          port_q  <= PORT_D;
          addr_q  <= d_req_addr[ADDR_W+1:0];
          size_q  <= d_req_size;
          we_q    <= d_req_we;
          wdata_q <= d_req_wdata;
        end
      end
    end
  end

  assign i_rsp_valid = i_rsp_valid_q;
  assign i_rsp_data  = i_rsp_data_q;
  assign d_rsp_valid = d_rsp_valid_q;
  assign d_rsp_data  = d_rsp_data_q;
  assign d_rsp_err   = d_rsp_err_q;

endmodule
